// File: rtl/socket_mem_sched.sv
// rtl/socket_mem_sched.sv - credit-limited round-robin scheduler onto one shared socket memory port
//
// Purpose: arbitrates NUM_REQS core request streams onto a single registered memory
// request port. The requester index is appended to the tag, and responses are routed
// back by that index. Each core may have at most MAX_PENDING reads outstanding. Writes
// are never credit-limited.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/rw/addr/data/tag per-core request lanes (flattened, lane i at [i*W +: W])
//   req_ready                  one-hot accept on the granted lane
//   mem_req_*                  registered shared request; mem_req_tag = {req_tag, index}
//   mem_rsp_*                  shared response; low SEL_BITS of the tag select the lane
//   rsp_valid/data/tag/ready   per-core response lanes (combinational from mem_rsp_*)
//   busy                       request registered or any read outstanding
//
// Optional: define SOCKET_MEM_SCHED_PERF_EN to add the saturating perf_stall_cycles and
// perf_credit_stalls counters.
module socket_mem_sched #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  localparam int SEL_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0]                req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]      req_tag,
  output logic [NUM_REQS-1:0]                req_ready,
  output logic                               mem_req_valid,
  output logic                               mem_req_rw,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr,
  output logic [DATA_WIDTH-1:0]              mem_req_data,
  output logic [TAG_WIDTH+SEL_BITS-1:0]      mem_req_tag,
  input  logic                               mem_req_ready,
  input  logic                               mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
  input  logic [TAG_WIDTH+SEL_BITS-1:0]      mem_rsp_tag,
  output logic                               mem_rsp_ready,
  output logic [NUM_REQS-1:0]                rsp_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]     rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]      rsp_tag,
  input  logic [NUM_REQS-1:0]                rsp_ready,
`ifdef SOCKET_MEM_SCHED_PERF_EN
  output logic [31:0]                        perf_stall_cycles,
  output logic [31:0]                        perf_credit_stalls,
`endif
  output logic                               busy
);

  localparam int CNT_W  = $clog2(MAX_PENDING + 1);
  localparam int MTAG_W = TAG_WIDTH + SEL_BITS;
  localparam logic [CNT_W-1:0]    MAX_CNT    = CNT_W'(MAX_PENDING);
  localparam logic [SEL_BITS:0]   NUM_REQS_W = (SEL_BITS + 1)'(NUM_REQS);
  localparam logic [SEL_BITS-1:0] LAST_IDX   = SEL_BITS'(NUM_REQS - 1);

  logic [SEL_BITS-1:0]   rr_ptr;
  logic [CNT_W-1:0]      pending [NUM_REQS];
  logic [NUM_REQS-1:0]   eligible;
  logic [NUM_REQS-1:0]   read_inc;
  logic [NUM_REQS-1:0]   rsp_dec;
  logic [NUM_REQS-1:0]   pend_nz;
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQS];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQS];
  logic [TAG_WIDTH-1:0]  tag_a  [NUM_REQS];
  logic                  grant_ok;
  logic                  grant;
  logic [SEL_BITS-1:0]   winner;
  logic [SEL_BITS-1:0]   rsp_sel;
  logic                  rsp_sel_ok;
  logic                  rsp_fire;

  assign rsp_sel    = mem_rsp_tag[SEL_BITS-1:0];
  assign rsp_sel_ok = {1'b0, rsp_sel} < NUM_REQS_W;
  assign rsp_fire   = mem_rsp_valid && mem_rsp_ready && rsp_sel_ok;
  // The output register can take a new request when it is empty or draining this cycle.
  assign grant_ok   = !mem_req_valid || mem_req_ready;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_lane
    assign addr_a[g]   = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[g]   = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign tag_a[g]    = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
    assign eligible[g] = req_valid[g] && (req_rw[g] || (pending[g] < MAX_CNT));
    assign read_inc[g] = grant && (winner == SEL_BITS'(g)) && !req_rw[g];
    assign rsp_dec[g]  = rsp_fire && (rsp_sel == SEL_BITS'(g));
    assign pend_nz[g]  = pending[g] != '0;
    assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = mem_rsp_valid ? mem_rsp_data : '0;
    assign rsp_tag[g*TAG_WIDTH +: TAG_WIDTH]    = mem_rsp_valid ? mem_rsp_tag[MTAG_W-1:SEL_BITS] : '0;
  end

  // Scan offsets from farthest to nearest so the nearest eligible lane after the
  // pointer is the last one written and therefore wins.
  always_comb begin
    logic [SEL_BITS:0] idx;
    idx    = '0;
    grant  = 1'b0;
    winner = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (SEL_BITS + 1)'(k);
      if (idx >= NUM_REQS_W) idx = idx - NUM_REQS_W;
      if (eligible[idx[SEL_BITS-1:0]]) begin
        grant  = grant_ok;
        winner = idx[SEL_BITS-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant && !reset) req_ready[winner] = 1'b1;
  end

  always_comb begin
    rsp_valid     = '0;
    mem_rsp_ready = 1'b1;  // out-of-range lanes are dropped
    if (rsp_sel_ok) begin
      rsp_valid[rsp_sel] = mem_rsp_valid;
      mem_rsp_ready      = rsp_ready[rsp_sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_tag   <= '0;
      rr_ptr        <= '0;
    end else begin
      if (grant) begin
        mem_req_valid <= 1'b1;
        mem_req_rw    <= req_rw[winner];
        mem_req_addr  <= addr_a[winner];
        mem_req_data  <= data_a[winner];
        mem_req_tag   <= {tag_a[winner], winner};
        rr_ptr        <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
      end else if (mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end
      assert (!(mem_rsp_valid && !rsp_sel_ok));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        assert (!(read_inc[i] && !rsp_dec[i] && pending[i] == MAX_CNT));
        assert (!(rsp_dec[i] && !read_inc[i] && pending[i] == '0));
        if (read_inc[i] && !rsp_dec[i]) pending[i] <= pending[i] + 1'b1;
        else if (rsp_dec[i] && !read_inc[i]) pending[i] <= pending[i] - 1'b1;
      end
    end
  end

  assign busy = mem_req_valid || (|pend_nz);

`ifdef SOCKET_MEM_SCHED_PERF_EN
  logic [NUM_REQS-1:0] credit_blk;
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_perf
    assign credit_blk[g] = req_valid[g] && !req_rw[g] && (pending[g] == MAX_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles  <= '0;
      perf_credit_stalls <= '0;
    end else begin
      if ((|req_valid) && !(|req_ready) && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if ((|credit_blk) && (perf_credit_stalls != '1))
        perf_credit_stalls <= perf_credit_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_socket_mem_sched.sv
// tb/tb_socket_mem_sched.sv - scoreboard bench for socket_mem_sched
`timescale 1ns/1ps
module tb_socket_mem_sched;
  localparam int N = 4, AW = 32, DW = 32, TW = 8, MAXP = 4, SB = 2, MTW = TW + SB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]    req_valid = '0, req_rw = '0, rsp_ready = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic            mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [DW-1:0]   mem_rsp_data = '0;
  logic [MTW-1:0]  mem_rsp_tag = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic            mem_req_valid, mem_req_rw, mem_rsp_ready, busy;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [MTW-1:0]  mem_req_tag;
  logic [N*DW-1:0] rsp_data;
  logic [N*TW-1:0] rsp_tag;
`ifdef SOCKET_MEM_SCHED_PERF_EN
  logic [31:0]     perf_stall_cycles, perf_credit_stalls;
`endif

  socket_mem_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
`ifdef SOCKET_MEM_SCHED_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_credit_stalls(perf_credit_stalls),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rw;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [MTW-1:0] tag;
  } req_t;

  req_t           exp_q[$];
  logic [MTW-1:0] mem_q[$];
  int n_cmp = 0, n_fail = 0;

  int  m_ptr = 0;
  int  m_pend[N] = '{default: 0};
  bit  m_full = 0;
  bit  m_rsp_fired = 0;
  longint m_stall = 0, m_cred = 0;
  bit  auto_rsp = 0;
  int  rsp_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request queue per lane is abstracted into a counter of
  // outstanding reads, and arbitration is "first eligible lane from the pointer".
  always @(negedge clk) begin
    int win, sel, i;
    bit fire, any_pend, cred;
    logic [N-1:0] exp_rdy, exp_rv;
    req_t e;
    if (reset) begin
      m_ptr = 0; m_full = 0; m_stall = 0; m_cred = 0;
      for (int k = 0; k < N; k++) m_pend[k] = 0;
      exp_q.delete();
    end else begin
      any_pend = 0;
      cred = 0;
      for (int k = 0; k < N; k++) if (m_pend[k] != 0) any_pend = 1;
      check("mem_req_valid", mem_req_valid, m_full);
      check("busy", busy, m_full || any_pend);
      win = -1;
      if (!m_full || mem_req_ready)
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (win < 0 && req_valid[i] && (req_rw[i] || m_pend[i] < MAXP)) win = i;
        end
      exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
      check("req_ready", req_ready, exp_rdy);
      sel = int'(mem_rsp_tag[SB-1:0]);
      exp_rv = mem_rsp_valid ? (N'(1) << sel) : '0;
      check("rsp_valid", rsp_valid, exp_rv);
      check("mem_rsp_ready", mem_rsp_ready, rsp_ready[sel]);
      if (mem_rsp_valid) begin
        check("rsp_data", rsp_data[sel*DW +: DW], mem_rsp_data);
        check("rsp_tag", rsp_tag[sel*TW +: TW], mem_rsp_tag[MTW-1:SB]);
      end
      fire = mem_rsp_valid && rsp_ready[sel];
      for (int k = 0; k < N; k++) if (req_valid[k] && !req_rw[k] && m_pend[k] == MAXP) cred = 1;
`ifdef SOCKET_MEM_SCHED_PERF_EN
      check("perf_stall_cycles", perf_stall_cycles, m_stall);
      check("perf_credit_stalls", perf_credit_stalls, m_cred);
`endif
      if ((|req_valid) && win < 0) m_stall++;
      if (cred) m_cred++;
      m_full = (win >= 0) || (m_full && !mem_req_ready);
      if (win >= 0) begin
        e.rw   = req_rw[win];
        e.addr = req_addr[win*AW +: AW];
        e.data = req_data[win*DW +: DW];
        e.tag  = {req_tag[win*TW +: TW], SB'(win)};
        exp_q.push_back(e);
        if (!e.rw) m_pend[win]++;
        m_ptr = (win + 1) % N;
      end
      if (fire) begin
        check("rsp_for_outstanding_read", m_pend[sel] > 0, 1);
        m_pend[sel]--;
        m_rsp_fired = 1;
      end
    end
  end

  // Monitor: every request leaving the shared port must match the oldest expected grant.
  always @(negedge clk) begin
    req_t e;
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        check("mem_req_expected", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("mem_req_rw", mem_req_rw, e.rw);
        check("mem_req_addr", mem_req_addr, e.addr);
        check("mem_req_data", mem_req_data, e.data);
        check("mem_req_tag", mem_req_tag, e.tag);
        if (!e.rw) mem_q.push_back(e.tag);
      end
    end
  end

  // Advance one cycle; in auto mode act as the memory returning reads in random order.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      if (m_rsp_fired) mem_q.delete(rsp_idx);
      if (mem_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        rsp_idx       = $urandom_range(mem_q.size() - 1, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = mem_q[rsp_idx];
        mem_rsp_data  = $urandom;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_tag   = MTW'($urandom);
      end
    end
    m_rsp_fired = 0;
  endtask

  initial begin
    int acc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
`ifdef SOCKET_MEM_SCHED_PERF_EN
    check("rst_perf_stall", perf_stall_cycles, 0);
    check("rst_perf_credit", perf_credit_stalls, 0);
`endif
    // Credit limit on lane 2: five reads, no responses.
    rsp_ready = '1;
    mem_req_ready = 1'b1;
    req_addr[2*AW +: AW] = 32'h0000_2000;
    req_tag[2*TW +: TW] = 8'h22;
    req_valid = 4'b0100;
    reset = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      acc += int'(req_ready[2]);
      step();
    end
    check("credit_accepts", acc, 4);
    #1;
    check("credit_stall", req_ready, 4'b0000);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = {8'h5A, 2'd2};
    mem_rsp_data = 32'hCAFE_0002;
    #1;
    check("route_valid", rsp_valid, 4'b0100);
    check("route_ready", mem_rsp_ready, 1);
    check("route_tag", rsp_tag[2*TW +: TW], 8'h5A);
    check("route_data_lane0", rsp_data[0 +: DW], 32'hCAFE_0002);
    check("stall_during_rsp", req_ready, 4'b0000);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("credit_regained", req_ready, 4'b0100);
    step();
    req_rw[2] = 1'b1;
    #1;
    check("write_bypass", req_ready, 4'b0100);
    step();
    req_rw[2] = 1'b0;
    #1;
    check("still_full", req_ready, 4'b0000);
    // Response back-pressure on lane 2.
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = {8'h5A, 2'd2};
    rsp_ready[2] = 1'b0;
    #1;
    check("rsp_hold_ready", mem_rsp_ready, 0);
    check("rsp_hold_valid", rsp_valid, 4'b0100);
    step();
    mem_rsp_valid = 1'b0;
    rsp_ready = '1;
    // Output stall: register a write, then hold mem_req_ready low.
    req_valid = '0;
    step();
    mem_req_ready = 1'b0;
    req_valid = 4'b0001;
    req_rw = 4'b0011;
    req_addr[0 +: AW] = 32'h1000_0000;
    step();
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", req_ready, 4'b0000);
      check("stall_addr", mem_req_addr, 32'h1000_0000);
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    check("drain_and_grant", req_ready, 4'b0010);
    step();
    // Reset with reads outstanding and a request registered.
    mem_req_ready = 1'b0;
    req_valid = 4'b1111;
    req_rw = 4'b0000;
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_req_valid", mem_req_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    step();
    step();
    mem_q.delete();
    reset = 1'b0;
    #1;
    check("ptr_after_rst", req_ready, 4'b0001);
    // Randomized traffic against the model.
    auto_rsp = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(3, 0) != 0);
        req_rw[i] = ($urandom_range(3, 0) == 0);
        req_addr[i*AW +: AW] = $urandom;
        req_data[i*DW +: DW] = $urandom;
        req_tag[i*TW +: TW] = TW'($urandom);
        rsp_ready[i] = ($urandom_range(3, 0) != 0);
      end
      mem_req_ready = ($urandom_range(9, 0) < 7);
    end
    req_valid = '0;
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/socket_mem_sched.md
Name: socket_mem_sched

Overview:
- Credit-limited round-robin scheduler that shares one socket-level memory port (dcache or icache slot) among NUM_REQS cores.
- Registers the winning request onto the shared port and extends its tag with the requester index.
- Routes responses back by that index.
- Caps each core's outstanding reads at MAX_PENDING, so one core cannot monopolise the port's response capacity.

Parameters:
- NUM_REQS, 4, number of requesting cores (>=1)
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, request/response data width
- TAG_WIDTH, 8, per-core request tag width
- MAX_PENDING, 4, max outstanding reads per requester (>=1)
- SEL_BITS, derived: max(1, clog2(NUM_REQS)), requester index width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  NUM_REQS  per-core request valid
- req_rw  in  NUM_REQS  1=write, 0=read
- req_addr  in  NUM_REQS*ADDR_WIDTH  per-core address
- req_data  in  NUM_REQS*DATA_WIDTH  per-core write data
- req_tag  in  NUM_REQS*TAG_WIDTH  per-core tag
- req_ready  out  NUM_REQS  per-core accept
- mem_req_valid  out  1  shared port request valid
- mem_req_rw  out  1  shared port rw
- mem_req_addr  out  ADDR_WIDTH  shared port address
- mem_req_data  out  DATA_WIDTH  shared port write data
- mem_req_tag  out  TAG_WIDTH+SEL_BITS  {req_tag, requester index}
- mem_req_ready  in  1  shared port accept
- mem_rsp_valid  in  1  shared port response valid
- mem_rsp_data  in  DATA_WIDTH  response data
- mem_rsp_tag  in  TAG_WIDTH+SEL_BITS  response tag
- mem_rsp_ready  out  1  response accept
- rsp_valid  out  NUM_REQS  per-core response valid
- rsp_data  out  NUM_REQS*DATA_WIDTH  per-core response data
- rsp_tag  out  NUM_REQS*TAG_WIDTH  per-core response tag
- rsp_ready  in  NUM_REQS  per-core response accept
- busy  out  1  request in flight or any read pending

Clock is clk. Reset is reset: asynchronous, active-high. Single clock domain.

Behaviour:
- Reset values:
  - mem_req_valid=0, all req_ready=0.
  - Round-robin pointer=0 (requester 0 highest priority).
  - All pending counters=0, busy=0.
  - Response outputs are combinational from mem_rsp_*, so they are 0 while mem_rsp_valid=0.
- Eligibility: requester i is eligible when req_valid[i] && (req_rw[i] || pending[i] < MAX_PENDING).
  - Writes are never credit-limited.
- Grant:
  - Output stage is one register.
  - Grant allowed when the register is empty or mem_req_ready=1 (drains the same cycle).
  - Winner is the first eligible index at or after the pointer, wrapping modulo NUM_REQS.
  - req_ready is one-hot on the winner, 0 elsewhere.
  - On a grant, the pointer becomes winner+1 (wraps to 0 after NUM_REQS-1); otherwise it holds.
- Latency and throughput:
  - A request accepted in cycle N is presented on mem_req_* in cycle N+1.
  - Sustained throughput is 1 request/cycle.
  - mem_req_* stay stable while mem_req_valid && !mem_req_ready.
- Tag: mem_req_tag = {req_tag[winner], winner[SEL_BITS-1:0]}. With NUM_REQS=1 the index bit is 0.
- Pending counter i (width clog2(MAX_PENDING+1)):
  - +1 on read accept from i.
  - −1 on response fire (mem_rsp_valid && mem_rsp_ready) with index i.
  - Simultaneous +1/−1 leaves it unchanged.
  - Overflow and underflow are assertion errors.
- Response routing, combinational:
  - sel = mem_rsp_tag[SEL_BITS-1:0].
  - rsp_valid[sel] = mem_rsp_valid; all other lanes 0.
  - All lanes carry mem_rsp_data and mem_rsp_tag[TAG_WIDTH+SEL_BITS-1:SEL_BITS].
  - mem_rsp_ready = rsp_ready[sel].
  - sel >= NUM_REQS: assertion error, response dropped (mem_rsp_ready=1).
- busy = mem_req_valid || any pending != 0.
- Reset mid-operation: all state returns to reset values immediately. In-flight responses arriving after reset are illegal.

Optional Feature:
- Macro: SOCKET_MEM_SCHED_PERF_EN.
- Defined: adds output perf_stall_cycles (32) and perf_credit_stalls (32), both reset to 0, saturating at all-ones.
  - perf_stall_cycles increments each cycle that |req_valid && !(|req_ready).
  - perf_credit_stalls increments each cycle in which some requester has req_valid=1, req_rw=0, pending=MAX_PENDING.
- Undefined: ports and counters absent; core behaviour is identical.

Test Plan:
- All 4 requesters issue continuous reads, mem_req_ready=1, responses returned next cycle -> grant order 0,1,2,3,0,1…, one mem_req per cycle, tag low 2 bits match the granted index.
- Requester 2 issues 5 reads, no responses, MAX_PENDING=4 -> 4 accepted, 5th stalls with req_ready[2]=0. One response with sel=2 -> 5th accepted the next cycle.
- Requester 1 holds a write while its pending=4 -> write accepted (no credit limit), pending stays 4.
- mem_req_ready=0 for 3 cycles with a request registered -> mem_req_* stable, req_ready all 0; ready=1 -> drain and new grant in the same cycle.
- Response tag {0x5A, 2'd3} with rsp_ready[3]=0 for 2 cycles -> rsp_valid[3]=1 only, mem_rsp_ready=0; accepted when rsp_ready[3]=1, pending[3] decrements.
- Reset asserted with 2 pending reads and mem_req_valid=1 -> immediately busy=0, mem_req_valid=0, pointer=0. PERF_EN build: perf counters=0 after reset, perf_credit_stalls counts 3 for 3 credit-blocked cycles.
